pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Drives load-enable and clear for IF/ID, the PC load-enable, load-enable and bubble-insert for ID/EX, and load-enables for EX/MEM and MEM/WB.
- Detects load-use hazards against the instruction held in IF/ID.
- Freezes the whole pipeline while data memory is not ready, and halts with an error on a memory timeout.
- Handles taken-branch flush per the delay-slot policy.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FREEZE  = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Opcodes of the instructions whose behaviour this controller reacts to
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_B       = 6'b000100;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of the load now in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // Register zero never carries a real dependency
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (ex_rt == id_rs)) ||
                     (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: memory freeze with timeout, load-use bubble, branch flush.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic             idex_le,
  output logic             idex_nop,
  output logic             exmem_le,
  output logic             memwb_le,
  output logic             halt_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

  state_t          state, state_next;
  logic [WC_W-1:0] wait_cnt, wait_next;
  logic            load_use;
  logic            mem_wait;
  logic            stall;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;
  assign stall    = (state == TIMEOUT) || mem_wait || load_use;

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    if (state != TIMEOUT) begin
      if (mem_wait) begin
        wait_next  = wait_cnt + WC_W'(1);
        state_next = (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) ? TIMEOUT : FREEZE;
      end else begin
        wait_next  = '0;
        state_next = RUN;
      end
    end
  end

  // Output mux in priority order; outputs act in the same cycle as the hazard
  always_comb begin
    pc_le    = 1'b1;
    ifid_le  = 1'b1;
    ifid_clr = 1'b0;
    idex_le  = 1'b1;
    idex_nop = 1'b0;
    exmem_le = 1'b1;
    memwb_le = 1'b1;
    if (reset) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      ifid_clr = 1'b1;
      idex_le  = 1'b0;
      idex_nop = 1'b1;
      exmem_le = 1'b0;
      memwb_le = 1'b0;
    end else if (state == TIMEOUT || mem_wait) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      idex_le  = 1'b0;
      exmem_le = 1'b0;
      memwb_le = 1'b0;
    end else if (load_use) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      idex_nop = 1'b1;
    end else if (branch_taken) begin
      ifid_clr = (DELAY_SLOT == 0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      halt_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == TIMEOUT)
        halt_err <= 1'b1;
      // Saturate rather than wrap so long stalls stay visible
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: table of single-cycle vectors plus freeze/timeout/saturation sequences.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;

  logic        pc_le_a, ifid_le_a, ifid_clr_a, idex_le_a, idex_nop_a, exmem_le_a, memwb_le_a, halt_a;
  logic [3:0]  stall_cnt_a;
  logic        pc_le_b, ifid_le_b, ifid_clr_b, idex_le_b, idex_nop_b, exmem_le_b, memwb_le_b, halt_b;
  logic [15:0] stall_cnt_b;
  logic [4:0]  le_a, le_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance a: delay slot, short timeout, narrow counter
  pipeline_hazard_ctrl #(.DELAY_SLOT(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_le(pc_le_a), .ifid_le(ifid_le_a), .ifid_clr(ifid_clr_a), .idex_le(idex_le_a),
    .idex_nop(idex_nop_a), .exmem_le(exmem_le_a), .memwb_le(memwb_le_a),
    .halt_err(halt_a), .stall_cnt(stall_cnt_a)
  );

  // Instance b: no delay slot, default timeout and counter width
  pipeline_hazard_ctrl #(.DELAY_SLOT(0), .MEM_TIMEOUT(16), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_le(pc_le_b), .ifid_le(ifid_le_b), .ifid_clr(ifid_clr_b), .idex_le(idex_le_b),
    .idex_nop(idex_nop_b), .exmem_le(exmem_le_b), .memwb_le(memwb_le_b),
    .halt_err(halt_b), .stall_cnt(stall_cnt_b)
  );

  assign le_a = {pc_le_a, ifid_le_a, idex_le_a, exmem_le_a, memwb_le_a};
  assign le_b = {pc_le_b, ifid_le_b, idex_le_b, exmem_le_b, memwb_le_b};

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mread;
    logic [4:0] xrt;
    logic       br, mreq, mrdy;
    logic [4:0] le;
    logic       clr1, clr0, nop;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic mread,
                               input logic [4:0] xrt, input logic br, input logic mreq,
                               input logic mrdy, input logic [4:0] le, input logic clr1,
                               input logic clr0, input logic nop, input logic [3:0] cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mread = mread; v.xrt = xrt;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.le = le; v.clr1 = clr1; v.clr0 = clr0;
    v.nop = nop; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_read = v.mread; ex_rt = v.xrt; branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic clearInputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    ex_rt = '0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic setLoadUse();
    clearInputs();
    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
  endtask

  initial begin
    //            rs  rt  urs urt rd xrt br rq rdy le        c1 c0 nop cnt
    vecs[0]  = mkv(0,  0,  0, 0, 0, 0,  0, 0, 0, 5'b11111, 0, 0, 0, 0);
    vecs[1]  = mkv(5,  0,  1, 0, 1, 5,  0, 0, 0, 5'b00111, 0, 0, 1, 1);
    vecs[2]  = mkv(0,  7,  0, 1, 1, 7,  0, 0, 0, 5'b00111, 0, 0, 1, 1);
    vecs[3]  = mkv(0,  0,  1, 0, 1, 0,  0, 0, 0, 5'b11111, 0, 0, 0, 0);
    vecs[4]  = mkv(5,  0,  0, 0, 1, 5,  0, 0, 0, 5'b11111, 0, 0, 0, 0);
    vecs[5]  = mkv(5,  0,  1, 0, 0, 5,  0, 0, 0, 5'b11111, 0, 0, 0, 0);
    vecs[6]  = mkv(0,  0,  0, 0, 0, 0,  1, 0, 0, 5'b11111, 0, 1, 0, 0);
    vecs[7]  = mkv(5,  0,  1, 0, 1, 5,  1, 0, 0, 5'b00111, 0, 0, 1, 1);
    vecs[8]  = mkv(0,  0,  0, 0, 0, 0,  0, 1, 0, 5'b00000, 0, 0, 0, 1);
    vecs[9]  = mkv(5,  0,  1, 0, 1, 5,  1, 1, 0, 5'b00000, 0, 0, 0, 1);
    vecs[10] = mkv(0,  0,  0, 0, 0, 0,  0, 1, 1, 5'b11111, 0, 0, 0, 0);
    vecs[11] = mkv(3,  9,  1, 0, 1, 9,  0, 0, 0, 5'b11111, 0, 0, 0, 0);

    // Reset held two cycles with random inputs
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); ex_mem_read = 1'($urandom);
      branch_taken = 1'($urandom); mem_req = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      checkOutput($sformatf("rst%0d_le_a", c), 16'(le_a), 16'h00);
      checkOutput($sformatf("rst%0d_le_b", c), 16'(le_b), 16'h00);
      checkOutput($sformatf("rst%0d_clr", c), 16'(ifid_clr_a), 16'h1);
      checkOutput($sformatf("rst%0d_nop", c), 16'(idex_nop_b), 16'h1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("post_rst_le", 16'(le_a), 16'h1f);
    checkOutput("post_rst_cnt", 16'(stall_cnt_a), 16'h0);
    checkOutput("post_rst_halt", 16'(halt_a), 16'h0);
    @(posedge clk); #1;

    // Table of single-cycle vectors, each from a fresh RUN state
    for (int i = 0; i < 12; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_le", i), 16'(le_a), 16'(vecs[i].le));
      checkOutput($sformatf("v%0d_clr_ds1", i), 16'(ifid_clr_a), 16'(vecs[i].clr1));
      checkOutput($sformatf("v%0d_clr_ds0", i), 16'(ifid_clr_b), 16'(vecs[i].clr0));
      checkOutput($sformatf("v%0d_nop", i), 16'(idex_nop_a), 16'(vecs[i].nop));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_cnt", i), 16'(stall_cnt_a), 16'(vecs[i].cnt));
      clearInputs();
    end

    // Three-cycle memory freeze then completion
    doReset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("frz%0d_le_a", c), 16'(le_a), 16'h00);
      checkOutput($sformatf("frz%0d_le_b", c), 16'(le_b), 16'h00);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(negedge clk);
    checkOutput("frz_done_le", 16'(le_a), 16'h1f);
    @(posedge clk); #1;
    checkOutput("frz_cnt_a", 16'(stall_cnt_a), 16'd3);
    checkOutput("frz_cnt_b", 16'(stall_cnt_b), 16'd3);
    checkOutput("frz_state", 16'(dut_a.state), 16'(RUN));
    clearInputs();

    // Timeout after four not-ready cycles on instance a
    doReset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("to%0d_le", c), 16'(le_a), 16'h00);
      checkOutput($sformatf("to%0d_halt", c), 16'(halt_a), 16'h0);
      @(posedge clk); #1;
    end
    checkOutput("to_halt_set", 16'(halt_a), 16'h1);
    mem_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("to_hold%0d_le", c), 16'(le_a), 16'h00);
      checkOutput($sformatf("to_hold%0d_nop", c), 16'(idex_nop_a), 16'h0);
      checkOutput($sformatf("to_hold%0d_halt", c), 16'(halt_a), 16'h1);
      @(posedge clk); #1;
    end
    checkOutput("to_cnt", 16'(stall_cnt_a), 16'd7);
    doReset();
    checkOutput("to_rst_halt", 16'(halt_a), 16'h0);
    checkOutput("to_rst_state", 16'(dut_a.state), 16'(RUN));
    clearInputs();

    // Twenty load-use stall cycles: a saturates at 15, b keeps counting
    doReset();
    setLoadUse();
    @(negedge clk);
    checkOutput("sat_le", 16'(le_a), 16'h07);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("sat_cnt_a", 16'(stall_cnt_a), 16'd15);
    checkOutput("sat_cnt_b", 16'(stall_cnt_b), 16'd20);
    @(posedge clk); #1;
    checkOutput("sat_hold_a", 16'(stall_cnt_a), 16'd15);

    // Reset mid-stall drops the stall at once
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_nop", 16'(idex_nop_a), 16'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("mid_rst_le", 16'(le_a), 16'h1f);
    checkOutput("mid_rst_cnt", 16'(stall_cnt_b), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
